// File: rtl/calc_alu_sequencer.sv
// calc_alu_sequencer: multi-cycle BCD calculator engine (load, add/sub/mul/div, double-dabble)
module calc_alu_sequencer #(
  parameter int DIGITS = 6,
  parameter int BIN_W  = 20
) (
  input  logic                  CLK_1K,
  input  logic                  RST,
  input  logic                  start,
  input  logic [3:0]            opcode,
  input  logic [4*DIGITS-1:0]   num_a,
  input  logic [4*DIGITS-1:0]   num_b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   num_result,
  output logic                  neg,
  output logic                  err
);
  localparam int DW = 4*DIGITS;
  localparam int CW = $clog2(BIN_W+1);
  localparam logic [2*BIN_W-1:0] MAX_V = (2*BIN_W)'(10**DIGITS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CONV, DONE} state_t;
  state_t state, state_n;
  logic [3:0] op;
  logic [DW-1:0] a_sh, b_sh, bcd, adj;
  logic [BIN_W-1:0] a_bin, b_bin, rem, bin_r, q_nxt;
  logic [2*BIN_W-1:0] acc, acc_nxt, res;
  logic [BIN_W:0] rem_sh, diff;
  logic [DW+BIN_W-1:0] dd;
  logic [CW-1:0] cnt;
  logic [3:0] dig_a, dig_b;
  logic bad, neg_p, err_p, valid_op, is_long, exec_last, q_bit, a_ge_b, err_n;
  assign valid_op  = opcode >= 4'ha && opcode <= 4'hd;
  assign is_long   = op == 4'hc || op == 4'hd;
  assign exec_last = !is_long || cnt == CW'(BIN_W-1);
  assign dig_a     = a_sh[DW-1 -: 4];
  assign dig_b     = b_sh[DW-1 -: 4];
  assign acc_nxt   = acc + (b_bin[cnt] ? ({{BIN_W{1'b0}}, a_bin} << cnt) : '0);
  // restoring divide: the dividend shifts out of a_bin while quotient bits shift in
  assign rem_sh    = {rem, a_bin[BIN_W-1]};
  assign diff      = rem_sh - {1'b0, b_bin};
  assign q_bit     = !diff[BIN_W];
  assign q_nxt     = {a_bin[BIN_W-2:0], q_bit};
  assign a_ge_b    = a_bin >= b_bin;
  assign res       = op == 4'ha ? (2*BIN_W)'(a_bin) + (2*BIN_W)'(b_bin)
                   : op == 4'hb ? (2*BIN_W)'(a_ge_b ? a_bin - b_bin : b_bin - a_bin)
                   : op == 4'hc ? acc_nxt : (2*BIN_W)'(q_nxt);
  assign err_n     = bad || (op == 4'hd && b_bin == '0) || res > MAX_V;
  assign dd        = {adj, bin_r} << 1;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start && valid_op ? LOAD : IDLE;
      LOAD:    state_n = cnt == CW'(DIGITS-1) ? EXEC : LOAD;
      EXEC:    state_n = exec_last ? CONV : EXEC;
      CONV:    state_n = cnt == CW'(BIN_W-1) ? DONE : CONV;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK_1K or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK_1K or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      op <= '0;
      a_sh <= '0;
      b_sh <= '0;
      a_bin <= '0;
      b_bin <= '0;
      acc <= '0;
      rem <= '0;
      bin_r <= '0;
      bcd <= '0;
      bad <= 1'b0;
      neg_p <= 1'b0;
      err_p <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      num_result <= '0;
      neg <= 1'b0;
      err <= 1'b0;
    end else begin
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      done <= state == DONE;
      case (state)
        IDLE: if (state_n == LOAD) begin
          op <= opcode;
          a_sh <= num_a;
          b_sh <= num_b;
          a_bin <= '0;
          b_bin <= '0;
          acc <= '0;
          rem <= '0;
          bad <= 1'b0;
          busy <= 1'b1;
        end
        LOAD: begin
          a_bin <= a_bin * BIN_W'(10) + BIN_W'(dig_a);
          b_bin <= b_bin * BIN_W'(10) + BIN_W'(dig_b);
          a_sh <= a_sh << 4;
          b_sh <= b_sh << 4;
          bad <= bad | (dig_a > 4'd9) | (dig_b > 4'd9);
        end
        EXEC: begin
          acc <= acc_nxt;
          rem <= op == 4'hd ? (q_bit ? diff[BIN_W-1:0] : rem_sh[BIN_W-1:0]) : rem;
          a_bin <= op == 4'hd ? q_nxt : a_bin;
          if (exec_last) begin
            bin_r <= err_n ? '0 : res[BIN_W-1:0];
            neg_p <= op == 4'hb && !a_ge_b && !err_n;
            err_p <= err_n;
            bcd <= '0;
          end
        end
        CONV: {bcd, bin_r} <= dd;
        DONE: begin
          num_result <= bcd;
          neg <= neg_p;
          err <= err_p;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_alu_sequencer.sv
// tb_calc_alu_sequencer: directed plus random checks against an integer-arithmetic reference model
`timescale 1ns/1ps
module tb_calc_alu_sequencer;
  logic CLK_1K = 1'b0, RST = 1'b0, start = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [23:0] num_a = '0, num_b = '0, num_result;
  logic busy, done, neg, err;
  int n_vec = 0, n_err = 0;
  logic [23:0] prev_res = '0;

  calc_alu_sequencer dut (
    .CLK_1K(CLK_1K), .RST(RST), .start(start), .opcode(opcode),
    .num_a(num_a), .num_b(num_b), .busy(busy), .done(done),
    .num_result(num_result), .neg(neg), .err(err)
  );

  always #5 CLK_1K = ~CLK_1K;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op,
                                output logic [23:0] r, output logic ng, output logic er);
    longint va = 0, vb = 0, v = 0;
    bit bad = 0;
    for (int i = 5; i >= 0; i--) begin
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) bad = 1;
      va = va * 10 + longint'(a[4*i +: 4]);
      vb = vb * 10 + longint'(b[4*i +: 4]);
    end
    ng = 0;
    case (op)
      4'ha: v = va + vb;
      4'hb: begin v = va >= vb ? va - vb : vb - va; ng = va < vb; end
      4'hc: v = va * vb;
      default: v = vb != 0 ? va / vb : 0;
    endcase
    er = bad || (op == 4'hd && vb == 0) || v > 999999;
    if (er) begin v = 0; ng = 0; end
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [3:0] op, input bit inject);
    logic [23:0] er_r;
    logic en, ee;
    int n, lat;
    model(a, b, op, er_r, en, ee);
    lat = (op == 4'hc || op == 4'hd) ? 47 : 28;
    @(negedge CLK_1K);
    num_a = a; num_b = b; opcode = op; start = 1'b1;
    @(posedge CLK_1K); #1;
    start = 1'b0;
    chk("busy_accept", 40'(busy), 40'd1);
    chk("result_hold", 40'(num_result), 40'(prev_res));
    for (n = 1; n <= 60; n++) begin
      @(posedge CLK_1K); #1;
      if (inject && n == 9) begin
        start = 1'b1; num_a = 24'h000777; num_b = 24'h000111; opcode = 4'ha;
      end
      if (inject && n == 10) start = 1'b0;
      if (done) break;
    end
    chk("done_edge", 40'(n), 40'(lat));
    chk("num_result", 40'(num_result), 40'(er_r));
    chk("neg", 40'(neg), 40'(en));
    chk("err", 40'(err), 40'(ee));
    chk("busy_done", 40'(busy), 40'd0);
    @(posedge CLK_1K); #1;
    chk("done_pulse", 40'(done), 40'd0);
    prev_res = er_r;
  endtask

  function automatic logic [23:0] rand_operand();
    int lims[4] = '{9, 999, 99999, 999999};
    int v = int'($urandom_range(0, lims[$urandom_range(0, 3)]));
    logic [23:0] r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    if ($urandom_range(0, 9) == 0) r[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
    return r;
  endfunction

  initial begin
    bit seen;
    #2;
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_done", 40'(done), 40'd0);
    chk("rst_result", 40'(num_result), 40'd0);
    chk("rst_neg", 40'(neg), 40'd0);
    chk("rst_err", 40'(err), 40'd0);
    @(negedge CLK_1K); RST = 1'b1;
    run_op(24'h000123, 24'h000456, 4'ha, 0);
    run_op(24'h000012, 24'h000345, 4'hb, 0);
    run_op(24'h999999, 24'h000001, 4'ha, 0);
    run_op(24'h001234, 24'h000567, 4'hc, 0);
    run_op(24'h999999, 24'h000002, 4'hc, 0);
    run_op(24'h000100, 24'h000007, 4'hd, 0);
    run_op(24'h000005, 24'h000000, 4'hd, 0);
    run_op(24'h000321, 24'h000100, 4'hb, 1);
    run_op(24'h00001A, 24'h000001, 4'ha, 0);
    @(negedge CLK_1K);
    num_a = 24'h000001; num_b = 24'h000001; opcode = 4'he; start = 1'b1;
    @(posedge CLK_1K); #1;
    start = 1'b0;
    chk("bad_op_busy", 40'(busy), 40'd0);
    seen = 0;
    repeat (30) begin @(posedge CLK_1K); #1; seen |= done | busy; end
    chk("bad_op_quiet", 40'(seen), 40'd0);
    @(negedge CLK_1K);
    num_a = 24'h001234; num_b = 24'h000567; opcode = 4'hc; start = 1'b1;
    @(posedge CLK_1K); #1;
    start = 1'b0;
    repeat (15) @(posedge CLK_1K);
    #1 RST = 1'b0;
    #1;
    chk("arst_busy", 40'(busy), 40'd0);
    chk("arst_done", 40'(done), 40'd0);
    chk("arst_result", 40'(num_result), 40'd0);
    chk("arst_err", 40'(err), 40'd0);
    @(negedge CLK_1K); RST = 1'b1;
    prev_res = '0;
    run_op(24'h000002, 24'h000003, 4'hc, 0);
    for (int k = 0; k < 40; k++)
      run_op(rand_operand(), rand_operand(), 4'ha + 4'($urandom_range(0, 3)), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
